// File: rtl/cam_msg_reader.sv
// cam_msg_reader: read-side controller for the FIX message CAM buffer.
// Accepts a start/end descriptor, reads each word (with address wrap),
// streams it over valid/ready with sop/eop, then pulses a release.
module cam_msg_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  msg_valid_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH-1:0] end_addr_i,
    output logic                  msg_ready_o,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic                  sop_o,
    output logic                  eop_o,
    output logic                  msg_done_o,
    output logic [ADDR_WIDTH-1:0] free_addr_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0]   remaining_q, remaining_d;  // words left after the current one
    logic                    first_q, first_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;

    logic last_word;
    assign last_word = (remaining_q == '0);

    // State and datapath registers; reset aborts any message in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            data_q      <= data_d;
        end
    end

    // Next-state and datapath update: one read, one capture, one send per word.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        data_d      = data_q;
        unique case (state_q)
            IDLE: begin
                if (msg_valid_i) begin
                    rd_ptr_d    = start_addr_i;
                    // Modular difference handles wrapped messages and the full buffer.
                    remaining_d = end_addr_i - start_addr_i;
                    first_d     = 1'b1;
                    state_d     = READ;
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                data_d  = rd_data_i;
                state_d = SEND;
            end
            SEND: begin
                if (data_ready_i) begin
                    if (last_word) begin
                        state_d = DONE;
                    end else begin
                        rd_ptr_d    = rd_ptr_q + 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        first_d     = 1'b0;
                        state_d     = READ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        msg_ready_o  = (state_q == IDLE);
        rd_en_o      = (state_q == READ);
        rd_addr_o    = rd_ptr_q;
        data_o       = data_q;
        data_valid_o = (state_q == SEND);
        sop_o        = (state_q == SEND) && first_q;
        eop_o        = (state_q == SEND) && last_word;
        msg_done_o   = (state_q == DONE);
        // rd_ptr sits on the last word in DONE, so +1 is the first free slot.
        free_addr_o  = rd_ptr_q + 1'b1;
    end

endmodule

// File: tb/tb_cam_msg_reader.sv
// Directed bench for cam_msg_reader: cycle-exact walk of each message.
module tb_cam_msg_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        msg_valid_i;
    logic [4:0]  start_addr_i, end_addr_i;
    logic        msg_ready_o, rd_en_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_i;
    logic [31:0] data_o;
    logic        data_valid_o, data_ready_i, sop_o, eop_o, msg_done_o;
    logic [4:0]  free_addr_o;

    logic [31:0] mem [32];
    int n_chk = 0;
    int n_err = 0;

    cam_msg_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .msg_valid_i  (msg_valid_i),
        .start_addr_i (start_addr_i),
        .end_addr_i   (end_addr_i),
        .msg_ready_o  (msg_ready_o),
        .rd_en_o      (rd_en_o),
        .rd_addr_o    (rd_addr_o),
        .rd_data_i    (rd_data_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .sop_o        (sop_o),
        .eop_o        (eop_o),
        .msg_done_o   (msg_done_o),
        .free_addr_o  (free_addr_o)
    );

    always #5 clk = ~clk;

    // Buffer model: synchronous read, data one cycle after rd_en.
    always @(posedge clk) if (rd_en_o) rd_data_i <= mem[rd_addr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, msg_ready_o, 1);
        chk({tag, "_rden"},  rd_en_o, 0);
        chk({tag, "_addr"},  rd_addr_o, 0);
        chk({tag, "_data"},  data_o, 0);
        chk({tag, "_vld"},   data_valid_o, 0);
        chk({tag, "_sop"},   sop_o, 0);
        chk({tag, "_eop"},   eop_o, 0);
        chk({tag, "_done"},  msg_done_o, 0);
        chk({tag, "_free"},  free_addr_o, 1);
    endtask

    // Runs one message, checking every cycle. Called in an IDLE cycle.
    // stall_k/stall_n: hold ready low stall_n cycles on word stall_k.
    // busy: present the next descriptor (bs,be) during the first SEND and leave it held.
    task automatic run_msg(input string tag, input logic [4:0] s, input logic [4:0] e,
                           input int n, input logic [4:0] free_exp,
                           input int stall_k, input int stall_n,
                           input bit busy, input logic [4:0] bs, input logic [4:0] be);
        logic [4:0]  a;
        logic [31:0] held;
        chk({tag, "_idle_ready"}, msg_ready_o, 1);
        msg_valid_i  = 1'b1;
        start_addr_i = s;
        end_addr_i   = e;
        step();                             // cycle 1
        msg_valid_i  = 1'b0;
        for (int k = 0; k < n; k++) begin
            a = s + k[4:0];
            chk({tag, "_rden"},  rd_en_o, 1);
            chk({tag, "_raddr"}, rd_addr_o, a);
            chk({tag, "_rd_vld"}, data_valid_o, 0);
            chk({tag, "_rd_ready"}, msg_ready_o, 0);
            step();                         // WAIT
            chk({tag, "_wait_rden"}, rd_en_o, 0);
            chk({tag, "_wait_vld"},  data_valid_o, 0);
            if (k == stall_k) data_ready_i = 1'b0;
            step();                         // SEND
            if (busy && k == 0) begin
                msg_valid_i  = 1'b1;
                start_addr_i = bs;
                end_addr_i   = be;
                #1;
                chk({tag, "_busy_ready"}, msg_ready_o, 0);
            end
            held = data_o;
            for (int j = 0; j < ((k == stall_k) ? stall_n : 0); j++) begin
                chk({tag, "_stall_vld"},  data_valid_o, 1);
                chk({tag, "_stall_data"}, data_o, held);
                chk({tag, "_stall_sop"},  sop_o, (k == 0));
                chk({tag, "_stall_rden"}, rd_en_o, 0);
                step();
            end
            data_ready_i = 1'b1;
            chk({tag, "_vld"},  data_valid_o, 1);
            chk({tag, "_data"}, data_o, mem[a]);
            chk({tag, "_sop"},  sop_o, (k == 0));
            chk({tag, "_eop"},  eop_o, (k == n - 1));
            chk({tag, "_send_rden"}, rd_en_o, 0);
            chk({tag, "_send_done"}, msg_done_o, 0);
            step();
        end
        chk({tag, "_done"}, msg_done_o, 1);
        chk({tag, "_free"}, free_addr_o, free_exp);
        chk({tag, "_done_vld"}, data_valid_o, 0);
        chk({tag, "_done_rden"}, rd_en_o, 0);
        step();                             // IDLE again
        chk({tag, "_end_ready"}, msg_ready_o, 1);
        chk({tag, "_end_done"},  msg_done_o, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i * 32'h0101;
        mem[7] = 32'hA5A5_0001;
        rd_data_i    = '0;
        msg_valid_i  = 1'b0;
        start_addr_i = '0;
        end_addr_i   = '0;
        data_ready_i = 1'b1;
        rst_n        = 1'b0;
        #2;
        chk_reset_outs("rst0");
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single word, start=end=7
        run_msg("one", 5'd7, 5'd7, 1, 5'd8, -1, 0, 0, 0, 0);
        // Four words 2..5
        run_msg("four", 5'd2, 5'd5, 4, 5'd6, -1, 0, 0, 0, 0);
        // Wrap 30,31,0,1
        run_msg("wrap", 5'd30, 5'd1, 4, 5'd2, -1, 0, 0, 0, 0);
        // Full buffer 0..31
        run_msg("full", 5'd0, 5'd31, 32, 5'd0, -1, 0, 0, 0, 0);
        // Backpressure: 5 stall cycles on word 1 of a 3-word message
        run_msg("bp", 5'd10, 5'd12, 3, 5'd13, 1, 5, 0, 0, 0);
        // Busy descriptor during SEND, held until accepted next
        run_msg("busyA", 5'd20, 5'd21, 2, 5'd22, -1, 0, 1, 5'd24, 5'd26);
        run_msg("busyB", 5'd24, 5'd26, 3, 5'd27, -1, 0, 0, 0, 0);

        // Reset mid-message, during SEND of the first word
        msg_valid_i  = 1'b1;
        start_addr_i = 5'd3;
        end_addr_i   = 5'd6;
        step();
        msg_valid_i  = 1'b0;
        step();
        step();
        chk("pre_rst_vld", data_valid_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rstmid");
        step();
        chk_reset_outs("rsthold");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_done",  msg_done_o, 0);
            chk("post_rst_ready", msg_ready_o, 1);
            chk("post_rst_rden",  rd_en_o, 0);
        end
        // Reader works again after the abort
        run_msg("after", 5'd7, 5'd8, 2, 5'd9, -1, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cam_msg_reader.md
# cam_msg_reader

Read-side controller for the FIX message CAM buffer. Takes a message descriptor (start and end word address) from the write-side controller once a message has been fully stored. Walks the buffer's read port from start to end, inclusive, with wrap-around, and streams each word out on a valid/ready interface with start/end-of-message markers. When the last word has been accepted it pulses a release so the writer can reclaim the space.

## Interface
- DATA_WIDTH, 32, width of one buffer word
- ADDR_WIDTH, 5, buffer address width; depth = 2^ADDR_WIDTH
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- msg_valid_i  in  1  descriptor present
- start_addr_i  in  ADDR_WIDTH  address of first word of message
- end_addr_i  in  ADDR_WIDTH  address of last word of message (inclusive)
- msg_ready_o  out  1  reader idle, descriptor accepted when msg_valid_i & msg_ready_o
- rd_en_o  out  1  buffer read strobe
- rd_addr_o  out  ADDR_WIDTH  buffer read address
- rd_data_i  in  DATA_WIDTH  buffer read data, valid in the cycle after rd_en_o
- data_o  out  DATA_WIDTH  message word
- data_valid_o  out  1  data_o valid
- data_ready_i  in  1  downstream accepts word
- sop_o  out  1  current word is first of message
- eop_o  out  1  current word is last of message
- msg_done_o  out  1  one-cycle pulse, message fully consumed
- free_addr_o  out  ADDR_WIDTH  end_addr + 1 (mod depth), valid while msg_done_o

## Operation
- FSM states: IDLE, READ, WAIT, SEND, DONE. All outputs are registered or decoded from registered state.
- IDLE: msg_ready_o=1. On msg_valid_i:
  - rd_ptr <= start_addr_i; remaining <= (end_addr_i - start_addr_i) mod 2^ADDR_WIDTH (ADDR_WIDTH bits; words after the first); first <= 1.
  - Go to READ.
- READ: rd_en_o=1, rd_addr_o=rd_ptr; go to WAIT.
- WAIT: data reg <= rd_data_i at end of cycle; go to SEND.
- SEND: data_valid_o=1, sop_o=first, eop_o=(remaining==0). data_o, sop_o and eop_o are held stable until handshake.
  - On data_ready_i with remaining==0: go to DONE.
  - On data_ready_i otherwise: rd_ptr <= rd_ptr+1 (wraps 2^ADDR_WIDTH-1 -> 0), remaining <= remaining-1, first <= 0, go to READ.
- DONE: msg_done_o=1, free_addr_o=rd_ptr+1 (wrapping); go to IDLE.
- Message length = remaining+1, from 1 to 2^ADDR_WIDTH words. start==end is 1 word; end==start-1 is the full buffer.
- msg_valid_i outside IDLE is ignored (msg_ready_o=0); no descriptor queueing. Upstream holds the descriptor until accepted.
- rd_en_o, data_valid_o and msg_done_o are never asserted together. No read is issued while a word awaits acceptance.
- sop_o, eop_o and data_o are don't-care when data_valid_o=0. The bench checks them only under data_valid_o.

## Timing
- Reset (rst_n low, asynchronous, immediate):
  - State IDLE; rd_ptr=0, remaining=0, first=0, data reg=0.
  - Outputs: msg_ready_o=1, rd_en_o=0, rd_addr_o=0, data_o=0, data_valid_o=0, sop_o=0, eop_o=0, msg_done_o=0, free_addr_o=1.
  - Descriptors are not accepted while rst_n is low.
- Reset mid-message aborts it with no msg_done_o. Reader resumes in IDLE on the first edge after deassertion.
- Descriptor accepted in cycle 0: rd_en_o in cycle 1, first data_valid_o in cycle 3.
- Each handshake in SEND at cycle t (not last): rd_en_o at t+1, next data_valid_o at t+3. Steady-state throughput is 1 word per 3 cycles with data_ready_i held high.
- N-word message with data_ready_i always high:
  - word k (k = 0..N-1) valid at cycle 3+3k;
  - msg_done_o at cycle 3N+1;
  - msg_ready_o=1 again at cycle 3N+2.
- Backpressure: extra cycles in SEND shift all later events one-for-one. Nothing is lost or duplicated.

## Test plan
- Reset: drive rst_n low mid-stream, then release -> all outputs at reset values immediately, including data_valid_o=0 and msg_ready_o=1. No msg_done_o for the aborted message.
- Single word, start=end=7, buffer[7]=0xA5A5_0001, ready high -> rd_addr_o=7 at cycle 1; data_o=0xA5A5_0001 with sop_o=eop_o=1 at cycle 3; msg_done_o at cycle 4 with free_addr_o=8.
- Four words, start=2, end=5, ready high -> rd_addr_o=2,3,4,5 at cycles 1,4,7,10; words valid at cycles 3,6,9,12; sop_o only at cycle 3, eop_o only at cycle 12; msg_done_o at cycle 13, free_addr_o=6.
- Wrap, ADDR_WIDTH=5, start=30, end=1 -> reads addresses 30,31,0,1 in order; 4 words; free_addr_o=2. Full buffer, start=0, end=31 -> 32 words; free_addr_o=0.
- Backpressure: hold data_ready_i=0 for 5 cycles on word 1 of a 3-word message -> data_valid_o, data_o and sop_o stay stable; rd_en_o=0 throughout; all later events shift by exactly 5 cycles.
- Busy descriptor: assert msg_valid_i with a new descriptor during SEND -> msg_ready_o=0, descriptor ignored. Hold it -> it is accepted in the first IDLE cycle after msg_done_o, and its first word is valid 3 cycles later.
